// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back / write-allocate data cache controller.
// One memory block per line; also walks the whole cache for a final dirty-line dump.
module dcache_ctrl #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 128,
  parameter int LINES      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [WORD_SIZE-1:0]  cpu_addr,
  input  logic [WORD_SIZE-1:0]  cpu_wdata,
  output logic [WORD_SIZE-1:0]  cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  cpu_flush,
  output logic [WORD_SIZE-1:0]  mem_in,
  output logic                  mem_readable,
  output logic                  mem_writable,
  output logic [BLOCK_SIZE-1:0] mem_write,
  input  logic [BLOCK_SIZE-1:0] mem_out1,
  input  logic [BLOCK_SIZE-1:0] mem_out2,
  output logic                  mem_flush
);

  localparam int WPL    = BLOCK_SIZE / WORD_SIZE;
  localparam int BYTE_W = $clog2(WORD_SIZE / 8);
  localparam int OFF_W  = $clog2(BLOCK_SIZE / 8);
  localparam int SEL_W  = $clog2(WPL);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;

  typedef enum logic [2:0] {IDLE, WB, FILL, WAIT, RESP, FLUSH, DONE} state_t;

  // Word 0 sits in the most significant slice of the line.
  function automatic logic [WORD_SIZE-1:0] get_word(input logic [BLOCK_SIZE-1:0] blk,
                                                    input logic [SEL_W-1:0] sel);
    get_word = blk[BLOCK_SIZE-1-int'(sel)*WORD_SIZE -: WORD_SIZE];
  endfunction

  function automatic logic [BLOCK_SIZE-1:0] put_word(input logic [BLOCK_SIZE-1:0] blk,
                                                     input logic [SEL_W-1:0] sel,
                                                     input logic [WORD_SIZE-1:0] wd);
    logic [BLOCK_SIZE-1:0] res;
    res = blk;
    res[BLOCK_SIZE-1-int'(sel)*WORD_SIZE -: WORD_SIZE] = wd;
    put_word = res;
  endfunction

  state_t state, nxt;

  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [BLOCK_SIZE-1:0] data_q [LINES];

  logic [WORD_SIZE-1:0]  req_addr;
  logic [WORD_SIZE-1:0]  req_wdata;
  logic                  req_we;
  logic [IDX_W-1:0]      flush_idx;

  logic [IDX_W-1:0]      cur_idx, r_idx;
  logic [TAG_W-1:0]      cur_tag, r_tag;
  logic [SEL_W-1:0]      cur_sel, r_sel;
  logic                  hit;
  logic                  accept;
  logic                  unused_bits;

  assign cur_idx = cpu_addr[OFF_W+IDX_W-1:OFF_W];
  assign cur_tag = cpu_addr[WORD_SIZE-1:OFF_W+IDX_W];
  assign cur_sel = cpu_addr[OFF_W-1:BYTE_W];
  assign r_idx   = req_addr[OFF_W+IDX_W-1:OFF_W];
  assign r_tag   = req_addr[WORD_SIZE-1:OFF_W+IDX_W];
  assign r_sel   = req_addr[OFF_W-1:BYTE_W];

  // Hit is judged on the live CPU address because it is only used in IDLE.
  assign hit    = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign accept = (state == IDLE) && cpu_req && !cpu_flush;

  // Second memory port and byte-offset bits carry nothing this controller needs.
  assign unused_bits = ^{mem_out2, cpu_addr[BYTE_W-1:0], req_addr[BYTE_W-1:0]};

  always_comb begin
    nxt          = state;
    cpu_ready    = 1'b0;
    mem_readable = 1'b0;
    mem_writable = 1'b0;
    mem_in       = '0;
    mem_write    = '0;
    mem_flush    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_flush) begin
          nxt = FLUSH;
        end else if (cpu_req) begin
          if (hit)                                       nxt = RESP;
          else if (valid_q[cur_idx] && dirty_q[cur_idx]) nxt = WB;
          else                                           nxt = FILL;
        end
      end
      WB: begin
        mem_writable = 1'b1;
        mem_in       = {tag_q[r_idx], r_idx, {OFF_W{1'b0}}};
        mem_write    = data_q[r_idx];
        nxt          = FILL;
      end
      FILL: begin
        mem_readable = 1'b1;
        mem_in       = {req_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
        nxt          = WAIT;
      end
      WAIT: nxt = RESP;
      RESP: begin
        cpu_ready = 1'b1;
        nxt       = IDLE;
      end
      FLUSH: begin
        if (valid_q[flush_idx] && dirty_q[flush_idx]) begin
          mem_writable = 1'b1;
          mem_in       = {tag_q[flush_idx], flush_idx, {OFF_W{1'b0}}};
          mem_write    = data_q[flush_idx];
        end
        if (flush_idx == IDX_W'(LINES - 1)) nxt = DONE;
      end
      DONE: mem_flush = 1'b1;
      default: nxt = IDLE;
    endcase
  end

  // Control state: FSM, line status bits, load result, flush cursor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      cpu_rdata <= '0;
      flush_idx <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (cpu_flush) flush_idx <= '0;
          if (accept && hit) begin
            if (cpu_we) dirty_q[cur_idx] <= 1'b1;
            else        cpu_rdata <= get_word(data_q[cur_idx], cur_sel);
          end
        end
        WAIT: begin
          valid_q[r_idx] <= 1'b1;
          dirty_q[r_idx] <= req_we;
          if (!req_we) cpu_rdata <= get_word(mem_out1, r_sel);
        end
        FLUSH: begin
          dirty_q[flush_idx] <= 1'b0;
          flush_idx          <= flush_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath storage: request latch, tags and line contents.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr  <= cpu_addr;
      req_we    <= cpu_we;
      req_wdata <= cpu_wdata;
      if (hit && cpu_we) data_q[cur_idx] <= put_word(data_q[cur_idx], cur_sel, cpu_wdata);
    end
    if (state == WAIT) begin
      tag_q[r_idx]  <= r_tag;
      data_q[r_idx] <= req_we ? put_word(mem_out1, r_sel, req_wdata) : mem_out1;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a cache-level reference model predicts
// responses, fills and write-backs; a negedge monitor compares them.
module tb_dcache_ctrl;
  localparam int W = 32;
  localparam int B = 128;
  localparam int L = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_we, cpu_flush;
  logic [W-1:0] cpu_addr, cpu_wdata, cpu_rdata, mem_in;
  logic         cpu_ready, mem_readable, mem_writable, mem_flush;
  logic [B-1:0] mem_write, mem_out1, mem_out2;

  dcache_ctrl #(.WORD_SIZE(W), .BLOCK_SIZE(B), .LINES(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_flush(cpu_flush),
    .mem_in(mem_in), .mem_readable(mem_readable), .mem_writable(mem_writable),
    .mem_write(mem_write), .mem_out1(mem_out1), .mem_out2(mem_out2), .mem_flush(mem_flush)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [B-1:0] act, input logic [B-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5C30F1E;
  endfunction

  // Backing memory (1 KiB, 64 blocks) seen by the DUT.
  logic [B-1:0] mem_blk [64];
  always @(posedge clk) begin
    mem_out2 <= {$urandom, $urandom, $urandom, $urandom};
    if (rst_n) begin
      if (mem_readable) mem_out1 <= mem_blk[mem_in[9:4]];
      if (mem_writable) mem_blk[mem_in[9:4]] <= mem_write;
    end
  end

  // Reference model: expected memory words plus expected cache contents.
  logic [31:0] em [256];
  bit          m_valid [L];
  bit          m_dirty [L];
  logic [23:0] m_tag   [L];
  logic [31:0] m_data  [L][4];

  typedef struct {
    logic [31:0] rdata;
    bit          is_load;
    int          lat;
    int          issued;
  } resp_t;
  typedef struct {
    logic [31:0] addr;
    logic [B-1:0] data;
  } wb_t;

  resp_t       rq[$];
  wb_t         wbq[$];
  logic [31:0] fillq[$];
  int          wb_pulses = 0;

  task automatic model_writeback(input int i);
    wb_t e;
    logic [3:0] ii;
    int base;
    ii     = i[3:0];
    e.addr = {m_tag[i], ii, 4'b0000};
    e.data = {m_data[i][0], m_data[i][1], m_data[i][2], m_data[i][3]};
    wbq.push_back(e);
    base = int'(e.addr[9:4]) * 4;
    for (int k = 0; k < 4; k++) em[base + k] = m_data[i][k];
  endtask

  task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              output resp_t r);
    int idx, w, base;
    idx = int'(addr[7:4]);
    w   = int'(addr[3:2]);
    r.is_load = !we;
    r.rdata   = '0;
    if (m_valid[idx] && m_tag[idx] == addr[31:8]) begin
      r.lat = 1;
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        model_writeback(idx);
        r.lat = 4;
      end else begin
        r.lat = 3;
      end
      fillq.push_back({addr[31:4], 4'b0000});
      base = int'(addr[9:4]) * 4;
      for (int k = 0; k < 4; k++) m_data[idx][k] = em[base + k];
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = addr[31:8];
    end
    if (we) begin
      m_data[idx][w] = wd;
      m_dirty[idx]   = 1'b1;
    end else begin
      r.rdata = m_data[idx][w];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("strobe_excl", B'(mem_readable & mem_writable), B'(0));
      if (cpu_ready) begin
        if (rq.size() == 0) chk("unexpected_ready", B'(1), B'(0));
        else begin
          resp_t r;
          r = rq.pop_front();
          chk("latency", B'(cyc - r.issued), B'(r.lat));
          if (r.is_load) chk("rdata", B'(cpu_rdata), B'(r.rdata));
        end
      end
      if (mem_readable) begin
        if (fillq.size() == 0) chk("unexpected_fill", B'(mem_in), B'(0));
        else chk("fill_addr", B'(mem_in), B'(fillq.pop_front()));
      end
      if (mem_writable) begin
        wb_pulses++;
        if (wbq.size() == 0) chk("unexpected_wb", B'(mem_in), B'(0));
        else begin
          wb_t e;
          e = wbq.pop_front();
          chk("wb_addr", B'(mem_in), B'(e.addr));
          chk("wb_data", mem_write, e.data);
        end
      end
    end
  end

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd);
    resp_t r;
    bit got;
    @(negedge clk);
    model_access(we, addr, wd, r);
    r.issued = cyc;
    rq.push_back(r);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk);
    #1;
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (cpu_ready) got = 1'b1;
    end
    if (!got) begin
      chk("ready_timeout", B'(0), B'(1));
      rq.delete();
    end
  endtask

  task automatic do_flush();
    int exp_wb;
    exp_wb = 0;
    @(negedge clk);
    for (int i = 0; i < L; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        model_writeback(i);
        m_dirty[i] = 1'b0;
        exp_wb++;
      end
    end
    wb_pulses = 0;
    cpu_flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100;
    @(posedge clk);
    #1;
    cpu_flush = 1'b0;
    repeat (L) @(negedge clk);
    chk("flush_not_yet_done", B'(mem_flush), B'(0));
    @(negedge clk);
    chk("mem_flush", B'(mem_flush), B'(1));
    chk("flush_wb_pulses", B'(wb_pulses), B'(exp_wb));
    chk("flush_wbq_empty", B'(wbq.size()), B'(0));
    cpu_flush = 1'b1;
    repeat (3) @(negedge clk);
    chk("done_sticky", B'(mem_flush), B'(1));
    cpu_flush = 1'b0; cpu_req = 1'b0;
  endtask

  task automatic check_memory();
    for (int b = 0; b < 64; b++)
      chk("mem_image", mem_blk[b], {em[4*b], em[4*b+1], em[4*b+2], em[4*b+3]});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mem_flush", B'(mem_flush), B'(0));
    chk("rst_rdata", B'(cpu_rdata), B'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) em[a] = init_word(32'(a * 4));
    for (int b = 0; b < 64; b++)
      mem_blk[b] = {init_word(32'(b*16)), init_word(32'(b*16+4)),
                    init_word(32'(b*16+8)), init_word(32'(b*16+12))};
    model_reset();
    rst_n = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_flush = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    #2 rst_n = 1'b0;
    #2;
    chk("reset_ready", B'(cpu_ready), B'(0));
    chk("reset_rdata", B'(cpu_rdata), B'(0));
    chk("reset_readable", B'(mem_readable), B'(0));
    chk("reset_writable", B'(mem_writable), B'(0));
    chk("reset_mem_flush", B'(mem_flush), B'(0));
    chk("reset_mem_in", B'(mem_in), B'(0));
    chk("reset_mem_write", mem_write, B'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Cold miss, store hit, load hit, then a dirty conflict at index 0.
    access(1'b0, 32'h0000_0100, 32'h0);
    access(1'b1, 32'h0000_0104, 32'hDEADBEEF);
    access(1'b0, 32'h0000_0104, 32'h0);
    access(1'b0, 32'h0000_0204, 32'h0);
    chk("wb_word1_in_memory", B'(mem_blk[6'h10][95:64]), B'(32'hDEADBEEF));

    for (int n = 0; n < 200; n++) begin
      logic [1:0]  t;
      logic [3:0]  ix;
      logic [1:0]  ws;
      t  = 2'($urandom_range(0, 3));
      ix = 4'($urandom_range(0, 15));
      ws = 2'($urandom_range(0, 3));
      access(1'($urandom_range(0, 1)), {22'b0, t, ix, ws, 2'b00}, $urandom);
    end

    do_flush();
    check_memory();
    do_reset();

    // Exactly two dirty lines (indices 0 and 5) plus one clean line.
    access(1'b1, 32'h0000_0100, 32'h1111_2222);
    access(1'b1, 32'h0000_0258, 32'h3333_4444);
    access(1'b0, 32'h0000_0090, 32'h0);
    do_flush();
    check_memory();
    do_reset();

    // Reset in the middle of a fill must kill the strobe and leave the line invalid.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0368;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    chk("fill_strobe", B'(mem_readable), B'(1));
    chk("fill_strobe_addr", B'(mem_in), B'(32'h0000_0360));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_kills_readable", B'(mem_readable), B'(0));
    chk("rst_kills_mem_in", B'(mem_in), B'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 32'h0000_0368, 32'h0);

    repeat (3) @(negedge clk);
    chk("resp_queue_drained", B'(rq.size()), B'(0));
    chk("fill_queue_drained", B'(fillq.size()), B'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
